// File: rtl/player_pkt_tx_if.sv
// ============================================================================
// player_pkt_tx_if : byte-wide valid/ready stream toward the UART transmitter
// Revision 1.0
// ============================================================================
`default_nettype none

interface player_pkt_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

`default_nettype wire

// File: rtl/player_pkt_tx.sv
// ============================================================================
// player_pkt_tx : snapshots local player state and sends it as an 8-byte
//                 packet (sync byte, payload, XOR checksum) once per frame tick
// Revision 1.0
// ============================================================================
`default_nettype none

module player_pkt_tx #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         PKT_LEN   = 8
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        send_tick,
  input  wire logic [11:0] char_x,
  input  wire logic [11:0] char_y,
  input  wire logic [3:0]  current_health,
  input  wire logic [3:0]  char_aggro,
  input  wire logic [6:0]  boss_hp,
  input  wire logic [1:0]  char_class,
  input  wire logic        flip_h,
  input  wire logic        game_start,
  player_pkt_tx_if.master  tx,
  output logic             busy,
  output logic             pkt_sent,
  output logic             tick_overrun
);

  localparam logic [2:0] LAST_IDX = 3'(PKT_LEN - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t     state_q;
  logic [2:0] byte_idx_q;
  logic       pending_q;
  logic [7:0] tx_data_q;
  logic       tx_valid_q;
  logic       pkt_sent_q;
  logic       tick_overrun_q;
  logic [7:0] pkt_q [1:7];
  logic [7:0] pkt_d [1:7];
  logic       xfer_last;

  // Payload bytes B1..B7 as they would be captured this cycle; B0 is the constant sync.
  always_comb begin
    pkt_d[1] = char_x[11:4];
    pkt_d[2] = {char_x[3:0], char_y[11:8]};
    pkt_d[3] = char_y[7:0];
    pkt_d[4] = {current_health, char_aggro};
    pkt_d[5] = {flip_h, boss_hp};
    pkt_d[6] = {game_start, 5'b00000, char_class};
    pkt_d[7] = pkt_d[1] ^ pkt_d[2] ^ pkt_d[3] ^ pkt_d[4] ^ pkt_d[5] ^ pkt_d[6];
  end

  assign xfer_last = (state_q == SEND) && tx.tx_ready && (byte_idx_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      byte_idx_q     <= 3'd0;
      pending_q      <= 1'b0;
      tx_data_q      <= 8'h00;
      tx_valid_q     <= 1'b0;
      pkt_sent_q     <= 1'b0;
      tick_overrun_q <= 1'b0;
      pkt_q          <= '{default: 8'h00};
    end else begin
      pkt_sent_q     <= 1'b0;
      tick_overrun_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (send_tick) begin
            pkt_q      <= pkt_d;
            byte_idx_q <= 3'd0;
            tx_data_q  <= SYNC_BYTE;
            tx_valid_q <= 1'b1;
            state_q    <= SEND;
          end
        end
        SEND: begin
          // Only one request queues; a tick on the final transfer is consumed by the restart.
          if (send_tick && !xfer_last) begin
            if (pending_q) tick_overrun_q <= 1'b1;
            else           pending_q      <= 1'b1;
          end
          if (tx.tx_ready) begin
            if (byte_idx_q != LAST_IDX) begin
              byte_idx_q <= byte_idx_q + 3'd1;
              tx_data_q  <= pkt_q[byte_idx_q + 3'd1];
            end else begin
              pkt_sent_q <= 1'b1;
              if (pending_q || send_tick) begin
                pkt_q      <= pkt_d;
                pending_q  <= 1'b0;
                byte_idx_q <= 3'd0;
                tx_data_q  <= SYNC_BYTE;
              end else begin
                tx_valid_q <= 1'b0;
                tx_data_q  <= 8'h00;
                state_q    <= IDLE;
              end
            end
          end
        end
      endcase
    end
  end

  assign tx.tx_data   = tx_data_q;
  assign tx.tx_valid  = tx_valid_q;
  assign busy         = (state_q == SEND);
  assign pkt_sent     = pkt_sent_q;
  assign tick_overrun = tick_overrun_q;

endmodule

`default_nettype wire
